// File: rtl/bcd_tick_timer.sv
// -----------------------------------------------------------------------------
// bcd_tick_timer
//
// Multi-digit BCD elapsed-time counter. It counts tick strobes from an upstream
// modulo divider under start / stop / clear control. The count is held as
// packed BCD (digit 0 in bits [3:0]) and is driven straight to the display path.
//
// Optional build macro:
//   BCD_TIMER_SATURATE_EN - when defined, an overflow holds the count at all
//                           nines, sets ovf and moves RUN -> HOLD, pulsing
//                           done. When undefined, the count wraps to zero,
//                           ovf is set and the timer stays in RUN.
//
// Parameters:
//   DIGITS    - number of BCD digits, legal range 1..8
//
// Ports:
//   clock     - system clock; all state changes happen on its rising edge
//   sreset    - synchronous reset, active-high, highest priority
//   tick      - count strobe; one count per cycle it is high while in RUN
//   start     - level; begin counting, or resume from HOLD
//   stop      - level; halt counting (RUN -> HOLD)
//   clear     - level; zero the count and the overflow flag
//   bcd_count - registered BCD count, 4*DIGITS bits
//   running   - registered, high while the FSM is in RUN
//   ovf       - registered sticky overflow flag
//   done      - registered one-cycle pulse on the edge that enters HOLD
// -----------------------------------------------------------------------------
module bcd_tick_timer #(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  sreset,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   bcd_count,
    output logic                  running,
    output logic                  ovf,
    output logic                  done
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Power-up values match the values forced by sreset.
    state_t         state_r   = IDLE;
    logic [W-1:0]   count_r   = {W{1'b0}};
    logic           ovf_r     = 1'b0;
    logic           running_r = 1'b0;
    logic           done_r    = 1'b0;

    state_t         state_s;
    logic [W-1:0]   count_s;
    logic           ovf_s;
    logic           running_s;
    logic           done_s;
    logic           sat_hold_s;

    // Ripple BCD increment: each digit only advances when everything below it
    // rolled from 9 to 0, so no nibble ever leaves the 0..9 range.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] value);
        logic [W-1:0] result;
        logic         carry;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value[4*i +: 4] == 4'd9) begin
                    result[4*i +: 4] = 4'd0;
                    carry            = 1'b1;
                end else begin
                    result[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end else begin
                result[4*i +: 4] = value[4*i +: 4];
            end
        end
        return result;
    endfunction

    // True when every digit is 9, i.e. the next tick overflows.
    function automatic logic all_nines(input logic [W-1:0] value);
        logic result;
        result = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (value[4*i +: 4] != 4'd9) begin
                result = 1'b0;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // Next-state, next-count and flag logic.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        ovf_s      = ovf_r;
        sat_hold_s = 1'b0;

        case (state_r)
            IDLE: begin
                // Count is already zero here; clear still zeroes ovf.
                if (clear) begin
                    count_s = {W{1'b0}};
                    ovf_s   = 1'b0;
                end else begin
                    count_s = count_r;
                end
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end

            RUN: begin
                // clear wins over a tick on the same edge.
                if (clear) begin
                    count_s = {W{1'b0}};
                    ovf_s   = 1'b0;
                end else if (tick) begin
                    if (all_nines(count_r)) begin
`ifdef BCD_TIMER_SATURATE_EN
                        count_s    = count_r;
                        ovf_s      = 1'b1;
                        sat_hold_s = 1'b1;
`else
                        count_s    = {W{1'b0}};
                        ovf_s      = 1'b1;
`endif
                    end else begin
                        count_s = bcd_inc(count_r);
                    end
                end else begin
                    count_s = count_r;
                end
                if (stop || sat_hold_s) begin
                    state_s = HOLD;
                end else begin
                    state_s = RUN;
                end
            end

            HOLD: begin
                // Count frozen; clear beats start.
                if (clear) begin
                    count_s = {W{1'b0}};
                    ovf_s   = 1'b0;
                    state_s = IDLE;
                end else if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = HOLD;
                end
            end

            default: begin
                // Unused encoding 3 recovers to IDLE.
                state_s = IDLE;
                if (clear) begin
                    count_s = {W{1'b0}};
                    ovf_s   = 1'b0;
                end else begin
                    count_s = count_r;
                end
            end
        endcase

        running_s = (state_s == RUN);
        done_s    = (state_r == RUN) && (state_s == HOLD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (sreset) begin
            state_r   <= IDLE;
            count_r   <= {W{1'b0}};
            ovf_r     <= 1'b0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            ovf_r     <= ovf_s;
            running_r <= running_s;
            done_r    <= done_s;
        end
    end

    assign bcd_count = count_r;
    assign running   = running_r;
    assign ovf       = ovf_r;
    assign done      = done_r;

endmodule

// File: tb/tb_bcd_tick_timer.sv
// -----------------------------------------------------------------------------
// tb_bcd_tick_timer
//
// Directed self-checking bench for bcd_tick_timer with DIGITS = 4. Inputs are
// changed 1 time unit after a rising edge; outputs are checked 1 time unit
// after the edge that should have produced them.
// -----------------------------------------------------------------------------
module tb_bcd_tick_timer;

    logic        clock;
    logic        sreset;
    logic        tick;
    logic        start;
    logic        stop;
    logic        clear;
    logic [15:0] bcd_count;
    logic        running;
    logic        ovf;
    logic        done;

    int checks;
    int errors;

    bcd_tick_timer #(.DIGITS(4)) dut (
        .clock     (clock),
        .sreset    (sreset),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .bcd_count (bcd_count),
        .running   (running),
        .ovf       (ovf),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic test_reset();
        sreset = 1'b1; tick = 1'b1; start = 1'b1; stop = 1'b0; clear = 1'b0;
        cyc();
        sreset = 1'b0; tick = 1'b0; start = 1'b0;
        checks++; if (bcd_count !== 16'h0000) begin errors++; $display("FAIL reset_count got %h exp %h", bcd_count, 16'h0000); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        // IDLE ignores ticks and stop
        tick = 1'b1; stop = 1'b1;
        cycles(3);
        tick = 1'b0; stop = 1'b0;
        checks++; if (bcd_count !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL idle_ignore got %h/%b exp 0000/0", bcd_count, running); end
    endtask

    task automatic test_basic_count();
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b exp 1", running); end
        for (int i = 0; i < 123; i++) begin
            tick = 1'b1; cyc(); tick = 1'b0; cycles(2);
        end
        checks++; if (bcd_count !== 16'h0123) begin errors++; $display("FAIL basic_count got %h exp %h", bcd_count, 16'h0123); end
        stop = 1'b1; cyc(); stop = 1'b0;
        checks++; if (done !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL stop_done got done=%b run=%b exp 1/0", done, running); end
        cyc();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width got %b exp 0", done); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", ovf); end
        // HOLD freezes the count
        tick = 1'b1; cycles(4); tick = 1'b0;
        checks++; if (bcd_count !== 16'h0123) begin errors++; $display("FAIL hold_frozen got %h exp %h", bcd_count, 16'h0123); end
        // resume from HOLD keeps the value
        start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1; cyc(); tick = 1'b0;
        checks++; if (bcd_count !== 16'h0124 || running !== 1'b1) begin errors++; $display("FAIL resume got %h/%b exp 0124/1", bcd_count, running); end
        stop = 1'b1; cyc(); stop = 1'b0;
        clear = 1'b1; cyc(); clear = 1'b0;
        checks++; if (bcd_count !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL hold_clear got %h/%b exp 0000/0", bcd_count, running); end
    endtask

    task automatic test_digit_carry();
        start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1; cycles(99); tick = 1'b0;
        checks++; if (bcd_count !== 16'h0099) begin errors++; $display("FAIL held_tick got %h exp %h", bcd_count, 16'h0099); end
        tick = 1'b1; cyc(); tick = 1'b0;
        checks++; if (bcd_count !== 16'h0100) begin errors++; $display("FAIL carry_0100 got %h exp %h", bcd_count, 16'h0100); end
        tick = 1'b1; cycles(899); tick = 1'b0;
        checks++; if (bcd_count !== 16'h0999) begin errors++; $display("FAIL count_0999 got %h exp %h", bcd_count, 16'h0999); end
        tick = 1'b1; cyc(); tick = 1'b0;
        checks++; if (bcd_count !== 16'h1000) begin errors++; $display("FAIL carry_1000 got %h exp %h", bcd_count, 16'h1000); end
    endtask

    task automatic test_overflow();
        tick = 1'b1; cycles(8998); tick = 1'b0;
        checks++; if (bcd_count !== 16'h9998 || ovf !== 1'b0) begin errors++; $display("FAIL count_9998 got %h/%b exp 9998/0", bcd_count, ovf); end
        tick = 1'b1; cyc();
        checks++; if (bcd_count !== 16'h9999 || ovf !== 1'b0) begin errors++; $display("FAIL count_9999 got %h/%b exp 9999/0", bcd_count, ovf); end
`ifdef BCD_TIMER_SATURATE_EN
        cyc();
        checks++; if (bcd_count !== 16'h9999 || ovf !== 1'b1 || running !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL sat_ovf got %h ovf=%b run=%b done=%b exp 9999/1/0/1", bcd_count, ovf, running, done); end
        cyc(); tick = 1'b0;
        checks++; if (bcd_count !== 16'h9999 || done !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL sat_hold got %h done=%b run=%b exp 9999/0/0", bcd_count, done, running); end
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL sat_restart got %b exp 1", running); end
        tick = 1'b1; cyc(); tick = 1'b0;
        checks++; if (bcd_count !== 16'h9999 || ovf !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL sat_again got %h ovf=%b done=%b exp 9999/1/1", bcd_count, ovf, done); end
        clear = 1'b1; cyc(); clear = 1'b0;
        checks++; if (bcd_count !== 16'h0000 || ovf !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL sat_clear got %h ovf=%b run=%b exp 0000/0/0", bcd_count, ovf, running); end
        start = 1'b1; cyc(); start = 1'b0;
`else
        cyc();
        checks++; if (bcd_count !== 16'h0000 || ovf !== 1'b1 || running !== 1'b1) begin errors++; $display("FAIL wrap got %h ovf=%b run=%b exp 0000/1/1", bcd_count, ovf, running); end
        cyc(); tick = 1'b0;
        checks++; if (bcd_count !== 16'h0001 || ovf !== 1'b1) begin errors++; $display("FAIL after_wrap got %h ovf=%b exp 0001/1", bcd_count, ovf); end
        clear = 1'b1; cyc(); clear = 1'b0;
        checks++; if (bcd_count !== 16'h0000 || ovf !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL ovf_clear got %h ovf=%b run=%b exp 0000/0/1", bcd_count, ovf, running); end
`endif
    endtask

    task automatic test_simultaneous();
        // RUN at 0000 on entry
        tick = 1'b1; cycles(41); tick = 1'b0;
        tick = 1'b1; stop = 1'b1; cyc(); tick = 1'b0; stop = 1'b0;
        checks++; if (bcd_count !== 16'h0042 || running !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL tick_stop got %h run=%b done=%b exp 0042/0/1", bcd_count, running, done); end
        clear = 1'b1; start = 1'b1; cyc(); clear = 1'b0; start = 1'b0;
        checks++; if (bcd_count !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL clear_start got %h/%b exp 0000/0", bcd_count, running); end
        tick = 1'b1; cyc(); tick = 1'b0;
        checks++; if (bcd_count !== 16'h0000) begin errors++; $display("FAIL idle_after_clear got %h exp 0000", bcd_count); end
        start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1; cycles(5);
        clear = 1'b1; cyc(); clear = 1'b0; tick = 1'b0;
        checks++; if (bcd_count !== 16'h0000 || running !== 1'b1) begin errors++; $display("FAIL tick_clear got %h/%b exp 0000/1", bcd_count, running); end
        tick = 1'b1; cycles(3); tick = 1'b0;
        clear = 1'b1; stop = 1'b1; cyc(); clear = 1'b0;
        checks++; if (bcd_count !== 16'h0000 || running !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL clear_stop got %h run=%b done=%b exp 0000/0/1", bcd_count, running, done); end
        cyc(); stop = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_held_done got %b exp 0", done); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; cyc(); start = 1'b0;
        tick = 1'b1; cycles(500);
        checks++; if (bcd_count !== 16'h0500) begin errors++; $display("FAIL count_0500 got %h exp %h", bcd_count, 16'h0500); end
        sreset = 1'b1; cyc(); sreset = 1'b0;
        checks++; if (bcd_count !== 16'h0000 || running !== 1'b0 || ovf !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset got %h run=%b ovf=%b done=%b exp 0000/0/0/0", bcd_count, running, ovf, done); end
        cycles(3); tick = 1'b0;
        checks++; if (bcd_count !== 16'h0000 || running !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %h/%b exp 0000/0", bcd_count, running); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sreset = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        #2;
        test_reset();
        test_basic_count();
        test_digit_carry();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
